// File: rtl/apb_bridge_decode.sv
// Registered APB bridge with address decode, fanning one upstream APB port out to G_NUM_SLAVES downstream ports.
// Optional ACCESS-phase timeout is compiled in with `define APB_BRIDGE_TIMEOUT_EN.
module apb_bridge_decode #(
  parameter int G_REGWIDTH   = 32,
  parameter int G_ADDR_WIDTH = 32,
  parameter int G_NUM_SLAVES = 4,
  parameter int G_SEL_LSB    = 12,
  parameter int G_TIMEOUT    = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_apb_psel,
  input  logic                                 s_apb_penable,
  input  logic                                 s_apb_pwrite,
  input  logic [2:0]                           s_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0]              s_apb_paddr,
  input  logic [G_REGWIDTH-1:0]                s_apb_pwdata,
  input  logic [G_REGWIDTH/8-1:0]              s_apb_pstrb,
  output logic                                 s_apb_pready,
  output logic [G_REGWIDTH-1:0]                s_apb_prdata,
  output logic                                 s_apb_pslverr,
  output logic [G_NUM_SLAVES-1:0]              m_apb_psel,
  output logic                                 m_apb_penable,
  output logic                                 m_apb_pwrite,
  output logic [2:0]                           m_apb_pprot,
  output logic [G_ADDR_WIDTH-1:0]              m_apb_paddr,
  output logic [G_REGWIDTH-1:0]                m_apb_pwdata,
  output logic [G_REGWIDTH/8-1:0]              m_apb_pstrb,
  input  logic [G_NUM_SLAVES-1:0]              m_apb_pready,
  input  logic [G_NUM_SLAVES*G_REGWIDTH-1:0]   m_apb_prdata,
  input  logic [G_NUM_SLAVES-1:0]              m_apb_pslverr
);

  localparam int SELW  = (G_NUM_SLAVES > 1) ? $clog2(G_NUM_SLAVES) : 1;
  localparam int STRBW = G_REGWIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state;
  logic [SELW-1:0]         idx_q;
  logic [SELW-1:0]         req_idx;
  logic                    req_hit;
  logic [G_NUM_SLAVES-1:0] req_onehot;
  logic                    sel_ready;
  logic                    sel_err;
  logic [G_REGWIDTH-1:0]   sel_rdata;
`ifdef APB_BRIDGE_TIMEOUT_EN
  logic [15:0]             to_cnt;
`endif

  // A single-slave bridge has no index field: everything maps to port 0.
  always_comb begin
    req_idx    = '0;
    req_onehot = '0;
    if (G_NUM_SLAVES > 1) req_idx = s_apb_paddr[G_SEL_LSB +: SELW];
    req_hit = (32'(req_idx) < 32'(G_NUM_SLAVES));
    for (int i = 0; i < G_NUM_SLAVES; i++) begin
      req_onehot[i] = (req_idx == SELW'(i));
    end
  end

  // Only the addressed slave's response is looked at; the rest are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < G_NUM_SLAVES; i++) begin
      if (idx_q == SELW'(i)) begin
        sel_ready = m_apb_pready[i];
        sel_err   = m_apb_pslverr[i];
        sel_rdata = m_apb_prdata[i*G_REGWIDTH +: G_REGWIDTH];
      end
    end
  end

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see pre-edge values; blocking assignments would create order-dependent logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      idx_q         <= '0;
      s_apb_pready  <= 1'b0;
      s_apb_prdata  <= '0;
      s_apb_pslverr <= 1'b0;
      m_apb_psel    <= '0;
      m_apb_penable <= 1'b0;
      m_apb_pwrite  <= 1'b0;
      m_apb_pprot   <= '0;
      m_apb_paddr   <= '0;
      m_apb_pwdata  <= '0;
      m_apb_pstrb   <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (s_apb_psel && s_apb_penable) begin
            m_apb_pwrite <= s_apb_pwrite;
            m_apb_pprot  <= s_apb_pprot;
            m_apb_paddr  <= s_apb_paddr;
            m_apb_pwdata <= s_apb_pwdata;
            m_apb_pstrb  <= s_apb_pwrite ? s_apb_pstrb : STRBW'(0);
            s_apb_prdata <= '0;
            if (req_hit) begin
              idx_q         <= req_idx;
              m_apb_psel    <= req_onehot;
              s_apb_pslverr <= 1'b0;
              state         <= SETUP;
            end else begin
              // Out-of-map: answer locally without touching the downstream bus.
              s_apb_pslverr <= 1'b1;
              s_apb_pready  <= 1'b1;
              state         <= RESP;
            end
          end
        end

        SETUP: begin
          m_apb_penable <= 1'b1;
`ifdef APB_BRIDGE_TIMEOUT_EN
          to_cnt        <= '0;
`endif
          state         <= ACCESS;
        end

        ACCESS: begin
          if (sel_ready) begin
            s_apb_prdata  <= sel_rdata;
            s_apb_pslverr <= sel_err;
            s_apb_pready  <= 1'b1;
            m_apb_psel    <= '0;
            m_apb_penable <= 1'b0;
            state         <= RESP;
          end
`ifdef APB_BRIDGE_TIMEOUT_EN
          // The cycle that would reach the limit is the last waited cycle.
          else if (to_cnt == 16'(G_TIMEOUT - 1)) begin
            to_cnt        <= to_cnt + 16'd1;
            s_apb_pslverr <= 1'b1;
            s_apb_pready  <= 1'b1;
            m_apb_psel    <= '0;
            m_apb_penable <= 1'b0;
            state         <= RESP;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end

        RESP: begin
          s_apb_pready <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_decode.sv
// Directed bench for apb_bridge_decode: a 4-slave bridge with modelled slaves plus a
// 3-slave bridge used for decode-error coverage.
module tb_apb_bridge_decode;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Shared upstream stimulus; use_b steers psel to the 3-slave instance.
  logic        use_b = 1'b0;
  logic        up_psel = 1'b0, up_pen = 1'b0, up_write = 1'b0;
  logic [2:0]  up_prot = '0;
  logic [31:0] up_addr = '0, up_wdata = '0;
  logic [3:0]  up_strb = '0;

  // Instance A: 4 slaves
  logic         a_pready, a_pslverr, a_m_pen, a_m_pwrite;
  logic [31:0]  a_prdata, a_m_paddr, a_m_pwdata;
  logic [3:0]   a_m_psel, a_m_pstrb, a_m_pready, a_m_pslverr;
  logic [2:0]   a_m_pprot;
  logic [127:0] a_m_prdata;

  // Instance B: 3 slaves, always ready
  logic         b_pready, b_pslverr, b_m_pen, b_m_pwrite;
  logic [31:0]  b_prdata, b_m_paddr, b_m_pwdata;
  logic [2:0]   b_m_psel, b_m_pready, b_m_pslverr, b_m_pprot;
  logic [3:0]   b_m_pstrb;
  logic [95:0]  b_m_prdata;

  apb_bridge_decode #(.G_NUM_SLAVES(4), .G_TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst),
    .s_apb_psel(up_psel & ~use_b), .s_apb_penable(up_pen), .s_apb_pwrite(up_write),
    .s_apb_pprot(up_prot), .s_apb_paddr(up_addr), .s_apb_pwdata(up_wdata), .s_apb_pstrb(up_strb),
    .s_apb_pready(a_pready), .s_apb_prdata(a_prdata), .s_apb_pslverr(a_pslverr),
    .m_apb_psel(a_m_psel), .m_apb_penable(a_m_pen), .m_apb_pwrite(a_m_pwrite),
    .m_apb_pprot(a_m_pprot), .m_apb_paddr(a_m_paddr), .m_apb_pwdata(a_m_pwdata),
    .m_apb_pstrb(a_m_pstrb), .m_apb_pready(a_m_pready), .m_apb_prdata(a_m_prdata),
    .m_apb_pslverr(a_m_pslverr)
  );

  apb_bridge_decode #(.G_NUM_SLAVES(3)) dut_b (
    .clk(clk), .rst(rst),
    .s_apb_psel(up_psel & use_b), .s_apb_penable(up_pen), .s_apb_pwrite(up_write),
    .s_apb_pprot(up_prot), .s_apb_paddr(up_addr), .s_apb_pwdata(up_wdata), .s_apb_pstrb(up_strb),
    .s_apb_pready(b_pready), .s_apb_prdata(b_prdata), .s_apb_pslverr(b_pslverr),
    .m_apb_psel(b_m_psel), .m_apb_penable(b_m_pen), .m_apb_pwrite(b_m_pwrite),
    .m_apb_pprot(b_m_pprot), .m_apb_paddr(b_m_paddr), .m_apb_pwdata(b_m_pwdata),
    .m_apb_pstrb(b_m_pstrb), .m_apb_pready(b_m_pready), .m_apb_prdata(b_m_prdata),
    .m_apb_pslverr(b_m_pslverr)
  );

  assign b_m_pready  = 3'b111;
  assign b_m_pslverr = 3'b000;
  assign b_m_prdata  = {32'h0000_0B02, 32'h0000_0B01, 32'h0000_0B00};

  // Slave models for instance A: configurable wait states, error flag, never-ready flag.
  int          waits [4];
  int          acc_cnt [4];
  logic [31:0] slv_rdata [4];
  logic [3:0]  dead = '0;
  logic [3:0]  err_cfg = '0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      waits[i]   = 0;
      acc_cnt[i] = 0;
    end
    slv_rdata[0] = 32'hC0DE_0000;
    slv_rdata[1] = 32'hC0DE_0001;
    slv_rdata[2] = 32'hC0DE_0002;
    slv_rdata[3] = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (a_m_psel[i] && a_m_pen && !a_m_pready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
      else acc_cnt[i] <= 0;
    end
  end

  always_comb begin
    a_m_pready  = '0;
    a_m_pslverr = '0;
    a_m_prdata  = '0;
    for (int i = 0; i < 4; i++) begin
      a_m_pready[i]           = a_m_psel[i] && a_m_pen && !dead[i] && (acc_cnt[i] >= waits[i]);
      a_m_pslverr[i]          = err_cfg[i];
      a_m_prdata[i*32 +: 32]  = slv_rdata[i];
    end
  end

  // Observed upstream response of whichever instance is addressed
  logic        o_pready, o_pslverr;
  logic [31:0] o_prdata;
  logic [3:0]  o_psel;
  assign o_pready  = use_b ? b_pready  : a_pready;
  assign o_pslverr = use_b ? b_pslverr : a_pslverr;
  assign o_prdata  = use_b ? b_prdata  : a_prdata;
  assign o_psel    = use_b ? {1'b0, b_m_psel} : a_m_psel;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-transfer observations, cycle numbers relative to T (first upstream access cycle)
  int          cyc, lat;
  logic [3:0]  psel_or, strb_or, psel_s1, psel_s2, psel_resp, strb_s1;
  logic        pen_s1, pen_s2, wr_s1, err_r;
  logic [31:0] addr_s1, wdata_s1, rdata_r;

  task automatic start_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic b);
    @(posedge clk); #1;
    use_b = b; up_psel = 1'b1; up_pen = 1'b0; up_write = wr;
    up_addr = addr; up_wdata = wdata; up_strb = strb; up_prot = 3'b010;
    @(posedge clk); #1;
    up_pen = 1'b1;
    cyc = 0; lat = -1; psel_or = '0; strb_or = '0;
  endtask

  task automatic wait_resp(input int budget);
    while (lat < 0 && cyc < budget) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      psel_or |= o_psel;
      if (!use_b) strb_or |= a_m_pstrb;
      if (cyc == 1) begin
        psel_s1 = o_psel; pen_s1 = use_b ? b_m_pen : a_m_pen;
        addr_s1 = a_m_paddr; wdata_s1 = a_m_pwdata; strb_s1 = a_m_pstrb; wr_s1 = a_m_pwrite;
      end
      if (cyc == 2) begin
        psel_s2 = o_psel; pen_s2 = use_b ? b_m_pen : a_m_pen;
      end
      if (o_pready) begin
        lat = cyc; rdata_r = o_prdata; err_r = o_pslverr; psel_resp = o_psel;
      end
    end
  endtask

  task automatic end_xfer();
    @(posedge clk); #1;
    up_psel = 1'b0; up_pen = 1'b0; use_b = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_outputs", |{a_pready, a_prdata, a_pslverr, a_m_psel, a_m_pen, a_m_pwrite,
                            a_m_pprot, a_m_paddr, a_m_pwdata, a_m_pstrb}, 0);
    check("rst_b_outputs", |{b_pready, b_prdata, b_pslverr, b_m_psel, b_m_pen, b_m_pwrite,
                            b_m_pprot, b_m_paddr, b_m_pwdata, b_m_pstrb}, 0);
    rst = 1'b1;

    // Zero-wait write to slave 1
    start_xfer(1'b1, 32'h0000_1004, 32'h1234_5678, 4'hF, 1'b0);
    wait_resp(20);
    check("wr1_lat", lat, 3);
    check("wr1_psel_setup", psel_s1, 4'b0010);
    check("wr1_pen_setup", pen_s1, 0);
    check("wr1_psel_access", psel_s2, 4'b0010);
    check("wr1_pen_access", pen_s2, 1);
    check("wr1_paddr", addr_s1, 32'h0000_1004);
    check("wr1_pwdata", wdata_s1, 32'h1234_5678);
    check("wr1_pstrb", strb_s1, 4'hF);
    check("wr1_pwrite", wr_s1, 1);
    check("wr1_pslverr", err_r, 0);
    check("wr1_psel_resp", psel_resp, 0);
    end_xfer();

    // Read from slave 3 with two wait states
    waits[3] = 2;
    start_xfer(1'b0, 32'h0000_3000, 32'h5555_5555, 4'hF, 1'b0);
    wait_resp(20);
    check("rd3_lat", lat, 5);
    check("rd3_prdata", rdata_r, 32'hDEAD_BEEF);
    check("rd3_pslverr", err_r, 0);
    check("rd3_pstrb_zero", strb_or, 0);
    check("rd3_psel_only3", psel_or, 4'b1000);
    end_xfer();

    // 3-slave instance: highest valid slave, then out-of-map index 3
    start_xfer(1'b0, 32'h0000_2000, 32'h0, 4'h0, 1'b1);
    wait_resp(20);
    check("b_rd2_lat", lat, 3);
    check("b_rd2_psel", psel_s1, 4'b0100);
    check("b_rd2_prdata", rdata_r, 32'h0000_0B02);
    end_xfer();
    start_xfer(1'b0, 32'h0000_3000, 32'h0, 4'h0, 1'b1);
    wait_resp(20);
    check("b_dec_lat", lat, 1);
    check("b_dec_pslverr", err_r, 1);
    check("b_dec_prdata", rdata_r, 0);
    check("b_dec_no_psel", psel_or, 0);
    end_xfer();

    // Slave error on write, held afterwards, then a clean read
    err_cfg[2] = 1'b1;
    start_xfer(1'b1, 32'h0000_2008, 32'hCAFE_F00D, 4'h3, 1'b0);
    wait_resp(20);
    check("err2_lat", lat, 3);
    check("err2_pslverr", err_r, 1);
    end_xfer();
    err_cfg[2] = 1'b0;
    @(negedge clk);
    check("err2_hold_pslverr", a_pslverr, 1);
    check("err2_pready_low", a_pready, 0);
    start_xfer(1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b0);
    wait_resp(20);
    check("rd0_pslverr", err_r, 0);
    check("rd0_prdata", rdata_r, 32'hC0DE_0000);
    end_xfer();

    // Reset during ACCESS, then recovery
    dead[0] = 1'b1;
    start_xfer(1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 1'b0);
    wait_resp(2);
    check("rst_mid_in_access", {a_m_psel, a_m_pen}, {4'b0001, 1'b1});
    #1 rst = 1'b0;
    #1;
    check("rst_mid_all_zero", |{a_pready, a_prdata, a_pslverr, a_m_psel, a_m_pen, a_m_pwrite,
                               a_m_pprot, a_m_paddr, a_m_pwdata, a_m_pstrb}, 0);
    up_psel = 1'b0; up_pen = 1'b0;
    dead[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    start_xfer(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 1'b0);
    wait_resp(20);
    check("post_rst_lat", lat, 3);
    check("post_rst_psel", psel_s1, 4'b0001);
    check("post_rst_pwdata", wdata_s1, 32'h0BAD_F00D);
    check("post_rst_pslverr", err_r, 0);
    end_xfer();

    // Slave 1 never ready
    dead[1] = 1'b1;
    start_xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, 1'b0);
`ifdef APB_BRIDGE_TIMEOUT_EN
    wait_resp(40);
    check("to_lat", lat, 10);
    check("to_pslverr", err_r, 1);
    check("to_prdata", rdata_r, 0);
    check("to_psel_resp", psel_resp, 0);
    dead[1] = 1'b0;
`else
    wait_resp(1100);
    check("noto_stuck", lat, -1);
    check("noto_still_access", {a_m_psel, a_m_pen}, {4'b0010, 1'b1});
    dead[1] = 1'b0;
    wait_resp(1200);
    check("noto_completes", lat > 1100, 1);
    check("noto_prdata", rdata_r, 32'hC0DE_0001);
    check("noto_pslverr", err_r, 0);
`endif
    end_xfer();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
